// File: rtl/unpacker_8to12.sv
// Unpacks a byte stream of little-endian 12-bit sample pairs (3 bytes per 2 samples)
// into 12-bit samples, with valid/ready on both sides and an in_sync triplet marker.
module unpacker_8to12 #(
   parameter int ERR_W = 8
) (
   input  logic             clk,
   input  logic             nreset,
   input  logic [7:0]       in_data,
   input  logic             in_valid,
   input  logic             in_sync,
   output logic             in_ready,
   output logic [11:0]      out_data,
   output logic             out_valid,
   output logic             out_first,
   input  logic             out_ready,
   output logic [ERR_W-1:0] sync_errors
);

   typedef enum logic [1:0] {P0, P1, P2} phase_t;

   phase_t           r_phase;
   logic [7:0]       r_lo_byte;
   logic [3:0]       r_hi_nib;
   logic [11:0]      r_out_data;
   logic             r_out_valid;
   logic             r_out_first;
   logic [ERR_W-1:0] r_sync_errors;

   phase_t w_phase_eff;
   logic   w_in_ready;
   logic   w_accept;
   logic   w_consume;

   // A sync-marked byte restarts the triplet, so it is judged as if the phase were P0.
   assign w_phase_eff = (in_valid && in_sync) ? P0 : r_phase;

   // P0 bytes only fill lo_byte, so they never wait on the output register.
   assign w_in_ready  = (w_phase_eff == P0) || !r_out_valid || out_ready;
   assign w_accept    = in_valid && w_in_ready;
   assign w_consume   = r_out_valid && out_ready;

   // NOTE: all state below uses non-blocking assignments so every register samples the
   // pre-edge values; the later load assignment deliberately overrides the consume clear.
   always_ff @(posedge clk) begin
      if (!nreset) begin
         r_phase       <= P0;
         r_lo_byte     <= '0;
         r_hi_nib      <= '0;
         r_out_data    <= '0;
         r_out_valid   <= 1'b0;
         r_out_first   <= 1'b0;
         r_sync_errors <= '0;
      end else begin
         if (w_consume)
            r_out_valid <= 1'b0;

         if (w_accept) begin
            if (in_sync && (r_phase != P0) && !(&r_sync_errors))
               r_sync_errors <= r_sync_errors + ERR_W'(1);

            case (w_phase_eff)
               P0: begin
                  r_lo_byte <= in_data;
                  r_phase   <= P1;
               end
               P1: begin
                  r_out_data  <= {in_data[3:0], r_lo_byte};
                  r_out_first <= 1'b1;
                  r_out_valid <= 1'b1;
                  r_hi_nib    <= in_data[7:4];
                  r_phase     <= P2;
               end
               P2: begin
                  r_out_data  <= {in_data, r_hi_nib};
                  r_out_first <= 1'b0;
                  r_out_valid <= 1'b1;
                  r_phase     <= P0;
               end
               default: r_phase <= P0;
            endcase
         end
      end
   end

   assign in_ready    = w_in_ready;
   assign out_data    = r_out_data;
   assign out_valid   = r_out_valid;
   assign out_first   = r_out_first;
   assign sync_errors = r_sync_errors;

endmodule
